// File: rtl/debug_loader_ctrl.sv
// debug_loader_ctrl: sequencing controller between the UART debug link and
// the MIPS pipeline. Loads LSB-first bytes into instruction memory, then runs
// or single-steps the pipeline and reports the executed-cycle count over TX.
// Optional feature macro: LOADER_STEP_EN (enables the STEP state).
//
// TX handshake: a byte transfers on every rising edge where o_tx_valid and
// i_tx_ready are both high; o_tx_data/o_tx_valid only change after such an
// edge (or when the first byte is presented), so the sink may stall forever.
module debug_loader_ctrl #(
  parameter int          NB_DATA       = 32,
  parameter int          NB_BYTE       = 8,
  parameter int          N_P_MEM_ADDR  = 128,
  parameter int          NB_P_MEM_ADDR = $clog2(N_P_MEM_ADDR),
  parameter logic [5:0]  HALT_OPCODE   = 6'b111111,
  parameter int          NB_CYCLES     = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NB_BYTE-1:0]       i_rx_data,
  input  logic                     i_rx_valid,
  output logic [NB_BYTE-1:0]       o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_imem_wr_en,
  output logic [NB_P_MEM_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0]       o_imem_data,
  output logic                     o_cpu_en,
  output logic                     o_cpu_reset,
  input  logic                     i_cpu_halt,
  output logic [2:0]               o_state
);

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    WAIT_CMD = 3'd1,
    RUN      = 3'd2,
    STEP     = 3'd3,
    REPORT   = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [NB_BYTE-1:0]       CMD_CONT   = 8'h63; // 'c'
  localparam logic [NB_BYTE-1:0]       CMD_STEP   = 8'h73; // 's'
  localparam logic [NB_BYTE-1:0]       CMD_TICK   = 8'h0A; // '\n'
  localparam logic [NB_BYTE-1:0]       CMD_RELOAD = 8'h72; // 'r'
  localparam int                       NB_TXW     = 4 * NB_BYTE;
  localparam logic [NB_P_MEM_ADDR-1:0] LAST_ADDR  = NB_P_MEM_ADDR'(N_P_MEM_ADDR - 1);

  state_t                   state;
  logic [1:0]               byte_cnt;
  logic [3*NB_BYTE-1:0]     word_buf;
  logic [NB_P_MEM_ADDR-1:0] wr_addr;
  logic [NB_CYCLES-1:0]     cycle_cnt;
  logic [1:0]               tx_idx;

  logic [NB_DATA-1:0]       rx_word;
  logic [NB_TXW-1:0]        cnt_ext;
  logic [1:0]               tx_idx_nxt;
  logic [NB_BYTE-1:0]       tx_byte_cur;
  logic [NB_BYTE-1:0]       tx_byte_nxt;

  assign o_state    = state;
  assign rx_word    = {i_rx_data, word_buf};
  assign cnt_ext    = NB_TXW'(cycle_cnt);
  assign tx_idx_nxt = tx_idx + 2'd1;

  // Select the current and following count bytes for the report sequence.
  always_comb begin
    tx_byte_cur = cnt_ext[tx_idx*NB_BYTE +: NB_BYTE];
    tx_byte_nxt = cnt_ext[tx_idx_nxt*NB_BYTE +: NB_BYTE];
  end

  // Control FSM with all counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state        <= LOAD;
      byte_cnt     <= 2'd0;
      word_buf     <= '0;
      wr_addr      <= '0;
      cycle_cnt    <= '0;
      tx_idx       <= 2'd0;
      o_tx_data    <= '0;
      o_tx_valid   <= 1'b0;
      o_imem_wr_en <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_data  <= '0;
      o_cpu_en     <= 1'b0;
      o_cpu_reset  <= 1'b1;
    end else begin
      o_imem_wr_en <= 1'b0;
      // Every enabled pipeline cycle counts, including the one that sees halt.
      if (o_cpu_en && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + NB_CYCLES'(1);

      case (state)
        LOAD: begin
          if (i_rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              o_imem_wr_en <= 1'b1;
              o_imem_addr  <= wr_addr;
              o_imem_data  <= rx_word;
              wr_addr      <= wr_addr + NB_P_MEM_ADDR'(1);
              // Stop on a HALT word or when the last address is written.
              if ((rx_word[NB_DATA-1 -: 6] == HALT_OPCODE) || (wr_addr == LAST_ADDR))
                state <= WAIT_CMD;
            end else begin
              word_buf[byte_cnt*NB_BYTE +: NB_BYTE] <= i_rx_data;
            end
          end
        end

        WAIT_CMD: begin
          o_cpu_reset <= 1'b1;
          if (i_rx_valid && (i_rx_data == CMD_CONT)) begin
            state       <= RUN;
            o_cpu_en    <= 1'b1;
            o_cpu_reset <= 1'b0;
          end
`ifdef LOADER_STEP_EN
          else if (i_rx_valid && (i_rx_data == CMD_STEP)) begin
            state       <= STEP;
            o_cpu_reset <= 1'b0;
          end
`endif
        end

        RUN: begin
          if (i_cpu_halt) begin
            o_cpu_en <= 1'b0;
            state    <= REPORT;
          end
        end

`ifdef LOADER_STEP_EN
        STEP: begin
          o_cpu_en <= 1'b0;
          // Halt takes priority over a same-edge tick or continue.
          if (i_cpu_halt) begin
            state <= REPORT;
          end else if (i_rx_valid && (i_rx_data == CMD_TICK)) begin
            o_cpu_en <= 1'b1;
          end else if (i_rx_valid && (i_rx_data == CMD_CONT)) begin
            o_cpu_en <= 1'b1;
            state    <= RUN;
          end
        end
`endif

        REPORT: begin
          o_cpu_en <= 1'b0;
          if (!o_tx_valid) begin
            // First byte is presented once the final count has settled.
            o_tx_data  <= tx_byte_cur;
            o_tx_valid <= 1'b1;
          end else if (i_tx_ready) begin
            if (tx_idx == 2'd3) begin
              o_tx_valid <= 1'b0;
              state      <= DONE;
            end else begin
              tx_idx    <= tx_idx_nxt;
              o_tx_data <= tx_byte_nxt;
            end
          end
        end

        DONE: begin
          o_cpu_en    <= 1'b0;
          o_cpu_reset <= 1'b0;
          if (i_rx_valid && (i_rx_data == CMD_RELOAD)) begin
            state       <= LOAD;
            byte_cnt    <= 2'd0;
            word_buf    <= '0;
            wr_addr     <= '0;
            cycle_cnt   <= '0;
            tx_idx      <= 2'd0;
            o_imem_addr <= '0;
            o_cpu_reset <= 1'b1;
          end
        end

        default: begin
          state    <= LOAD;
          o_cpu_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_loader_ctrl.sv
// Directed testbench for debug_loader_ctrl. Inputs are driven 2 time units
// after the rising edge; outputs are observed on the falling edge.
module tb_debug_loader_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       imem_wr_en;
  logic [6:0] imem_addr;
  logic [31:0] imem_data;
  logic       cpu_en;
  logic       cpu_reset;
  logic       cpu_halt;
  logic [2:0] state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [6:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] exp_q[$];
  int          runs_q[$];
  int          en_cnt  = 0;
  int          run_len = 0;

  debug_loader_ctrl dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_tx_data    (tx_data),
    .o_tx_valid   (tx_valid),
    .i_tx_ready   (tx_ready),
    .o_imem_wr_en (imem_wr_en),
    .o_imem_addr  (imem_addr),
    .o_imem_data  (imem_data),
    .o_cpu_en     (cpu_en),
    .o_cpu_reset  (cpu_reset),
    .i_cpu_halt   (cpu_halt),
    .o_state      (state)
  );

  // Clock
  always #5 clk = ~clk;

  // Monitor: log writes, TX transfers and cpu_en pulse lengths.
  always @(negedge clk) begin
    if (imem_wr_en) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_data);
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (cpu_en) begin
      en_cnt++;
      run_len++;
    end else if (run_len != 0) begin
      runs_q.push_back(run_len);
      run_len = 0;
    end
  end

  // Driver: one-cycle rx_valid pulse.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #2;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #2;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (state !== 3'd0) begin tests_failed++; $display("FAIL reset_state got %0d exp 0", state); end
    tests_run++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx got v=%b d=%h exp v=0 d=00", tx_valid, tx_data); end
    tests_run++; if (imem_wr_en !== 1'b0 || imem_addr !== 7'd0 || imem_data !== 32'd0) begin tests_failed++; $display("FAIL reset_imem got we=%b a=%0d d=%h exp 0/0/0", imem_wr_en, imem_addr, imem_data); end
    tests_run++; if (cpu_en !== 1'b0 || cpu_reset !== 1'b1) begin tests_failed++; $display("FAIL reset_cpu got en=%b rst=%b exp en=0 rst=1", cpu_en, cpu_reset); end
  endtask

  task automatic test_load3();
    exp_q.delete();
    exp_q.push_back(32'h11223344);
    exp_q.push_back(32'hA5A55A5A);
    exp_q.push_back(32'hFC000000);
    wr_addr_q.delete(); wr_data_q.delete();
    send_word(exp_q[0]);
    send_word(exp_q[1]);
    @(negedge clk);
    tests_run++; if (state !== 3'd0) begin tests_failed++; $display("FAIL load3_mid_state got %0d exp 0", state); end
    send_word(exp_q[2]);
    repeat (2) @(negedge clk);
    tests_run++; if (wr_addr_q.size() !== 3) begin tests_failed++; $display("FAIL load3_count got %0d exp 3", wr_addr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < wr_addr_q.size()) begin
        tests_run++;
        if (wr_addr_q[i] !== 7'(i) || wr_data_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL load3_write%0d got a=%0d d=%h exp a=%0d d=%h", i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
        end
      end
    end
    tests_run++; if (state !== 3'd1 || cpu_reset !== 1'b1) begin tests_failed++; $display("FAIL load3_wait got st=%0d rst=%b exp st=1 rst=1", state, cpu_reset); end
  endtask

  task automatic test_run();
    tx_q.delete(); runs_q.delete(); en_cnt = 0;
    tx_ready = 1'b1;
    send_byte(8'h63);
    @(negedge clk);
    tests_run++; if (cpu_en !== 1'b1 || cpu_reset !== 1'b0 || state !== 3'd2) begin tests_failed++; $display("FAIL run_start got en=%b rst=%b st=%0d exp 1/0/2", cpu_en, cpu_reset, state); end
    repeat (10) @(posedge clk);
    #2 cpu_halt = 1'b1;
    @(posedge clk); #2 cpu_halt = 1'b0;
    for (int i = 0; i < 60 && state !== 3'd5; i++) @(negedge clk);
    tests_run++; if (state !== 3'd5) begin tests_failed++; $display("FAIL run_done got st=%0d exp 5", state); end
    tests_run++; if (en_cnt !== 11 || runs_q.size() !== 1) begin tests_failed++; $display("FAIL run_en_cycles got %0d in %0d runs exp 11 in 1", en_cnt, runs_q.size()); end
    tests_run++; if (tx_q.size() !== 4) begin tests_failed++; $display("FAIL run_tx_count got %0d exp 4", tx_q.size()); end
    else begin
      tests_run++; if (tx_q[0] !== 8'h0B || tx_q[1] !== 8'h00 || tx_q[2] !== 8'h00 || tx_q[3] !== 8'h00) begin tests_failed++; $display("FAIL run_tx_bytes got %h %h %h %h exp 0b 00 00 00", tx_q[0], tx_q[1], tx_q[2], tx_q[3]); end
    end
    tests_run++; if (cpu_reset !== 1'b0 || cpu_en !== 1'b0 || tx_valid !== 1'b0) begin tests_failed++; $display("FAIL done_outputs got rst=%b en=%b txv=%b exp 0/0/0", cpu_reset, cpu_en, tx_valid); end
  endtask

  task automatic test_reload();
    send_byte(8'h72);
    @(negedge clk);
    tests_run++; if (state !== 3'd0 || imem_addr !== 7'd0 || cpu_reset !== 1'b1) begin tests_failed++; $display("FAIL reload got st=%0d a=%0d rst=%b exp 0/0/1", state, imem_addr, cpu_reset); end
  endtask

  task automatic test_full_load();
    logic addr_ok;
    wr_addr_q.delete(); wr_data_q.delete();
    for (int i = 0; i < 128; i++) send_word(32'h0010_0000 | 32'(i));
    repeat (2) @(negedge clk);
    tests_run++; if (wr_addr_q.size() !== 128) begin tests_failed++; $display("FAIL full_count got %0d exp 128", wr_addr_q.size()); end
    else begin
      addr_ok = 1'b1;
      for (int i = 0; i < 128; i++)
        if (wr_addr_q[i] !== 7'(i) || wr_data_q[i] !== (32'h0010_0000 | 32'(i))) addr_ok = 1'b0;
      tests_run++; if (addr_ok !== 1'b1) begin tests_failed++; $display("FAIL full_sequence got last a=%0d d=%h exp a=127 d=0010007f", wr_addr_q[127], wr_data_q[127]); end
    end
    tests_run++; if (state !== 3'd1) begin tests_failed++; $display("FAIL full_state got %0d exp 1", state); end
    send_word(32'h44332211);
    repeat (2) @(negedge clk);
    tests_run++; if (wr_addr_q.size() !== 128 || state !== 3'd1) begin tests_failed++; $display("FAIL full_overflow got writes=%0d st=%0d exp 128/1", wr_addr_q.size(), state); end
  endtask

  task automatic test_tx_stall();
    logic stable_ok;
    tx_q.delete(); en_cnt = 0;
    tx_ready = 1'b0;
    send_byte(8'h63);
    repeat (4) @(posedge clk);
    #2 cpu_halt = 1'b1;
    @(posedge clk); #2 cpu_halt = 1'b0;
    repeat (2) @(negedge clk);
    stable_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'h05 || state !== 3'd4) stable_ok = 1'b0;
      @(negedge clk);
    end
    tests_run++; if (stable_ok !== 1'b1) begin tests_failed++; $display("FAIL stall_hold got v=%b d=%h st=%0d exp v=1 d=05 st=4", tx_valid, tx_data, state); end
    tests_run++; if (tx_q.size() !== 0) begin tests_failed++; $display("FAIL stall_no_xfer got %0d exp 0", tx_q.size()); end
    @(posedge clk); #2 tx_ready = 1'b1;
    for (int i = 0; i < 40 && state !== 3'd5; i++) @(negedge clk);
    tests_run++; if (tx_q.size() !== 4) begin tests_failed++; $display("FAIL stall_tx_count got %0d exp 4", tx_q.size()); end
    else begin
      tests_run++; if (tx_q[0] !== 8'h05 || tx_q[1] !== 8'h00 || tx_q[2] !== 8'h00 || tx_q[3] !== 8'h00) begin tests_failed++; $display("FAIL stall_tx_bytes got %h %h %h %h exp 05 00 00 00", tx_q[0], tx_q[1], tx_q[2], tx_q[3]); end
    end
  endtask

  task automatic test_step();
    send_word(32'hFC000000);
    repeat (2) @(negedge clk);
    tests_run++; if (state !== 3'd1) begin tests_failed++; $display("FAIL step_load got st=%0d exp 1", state); end
    tx_q.delete(); runs_q.delete(); en_cnt = 0;
    tx_ready = 1'b1;
    send_byte(8'h73);
`ifdef LOADER_STEP_EN
    @(negedge clk);
    tests_run++; if (state !== 3'd3 || cpu_en !== 1'b0) begin tests_failed++; $display("FAIL step_enter got st=%0d en=%b exp 3/0", state, cpu_en); end
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h0A);
      repeat (3) @(posedge clk);
    end
    // Halt and a tick on the same edge: no pulse expected.
    @(posedge clk); #2;
    rx_data = 8'h0A; rx_valid = 1'b1; cpu_halt = 1'b1;
    @(posedge clk); #2;
    rx_valid = 1'b0; cpu_halt = 1'b0;
    for (int i = 0; i < 40 && state !== 3'd5; i++) @(negedge clk);
    tests_run++; if (en_cnt !== 3 || runs_q.size() !== 3) begin tests_failed++; $display("FAIL step_pulses got %0d cycles in %0d pulses exp 3 in 3", en_cnt, runs_q.size()); end
    tests_run++; if (tx_q.size() !== 4) begin tests_failed++; $display("FAIL step_tx_count got %0d exp 4", tx_q.size()); end
    else begin
      tests_run++; if (tx_q[0] !== 8'h03 || tx_q[1] !== 8'h00 || tx_q[2] !== 8'h00 || tx_q[3] !== 8'h00) begin tests_failed++; $display("FAIL step_tx_bytes got %h %h %h %h exp 03 00 00 00", tx_q[0], tx_q[1], tx_q[2], tx_q[3]); end
    end
`else
    send_byte(8'h0A);
    repeat (2) @(negedge clk);
    tests_run++; if (state !== 3'd1 || en_cnt !== 0) begin tests_failed++; $display("FAIL step_disabled got st=%0d en_cycles=%0d exp 1/0", state, en_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_reset();
    @(negedge clk);
    tests_run++; if (state !== 3'd0 || cpu_reset !== 1'b1 || tx_valid !== 1'b0 || imem_addr !== 7'd0) begin tests_failed++; $display("FAIL midreset_state got st=%0d rst=%b txv=%b a=%0d exp 0/1/0/0", state, cpu_reset, tx_valid, imem_addr); end
    wr_addr_q.delete(); wr_data_q.delete();
    send_word(32'h12345678);
    repeat (2) @(negedge clk);
    tests_run++; if (wr_addr_q.size() !== 1) begin tests_failed++; $display("FAIL midreset_count got %0d exp 1", wr_addr_q.size()); end
    else begin
      tests_run++; if (wr_addr_q[0] !== 7'd0 || wr_data_q[0] !== 32'h12345678) begin tests_failed++; $display("FAIL midreset_word got a=%0d d=%h exp a=0 d=12345678", wr_addr_q[0], wr_data_q[0]); end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    cpu_halt = 1'b0;
    test_reset();
    test_load3();
    test_run();
    test_reload();
    test_full_load();
    test_tx_stall();
    test_reload();
    test_step();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
